// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the sram port arbiter.
//   MST_INST / MST_DATA : requester ids carried in the response tag FIFO.
//   MAX_OUTST_DEFAULT   : default limit on accepted-but-unanswered transactions.
//   ptr_width()         : FIFO pointer width, at least one bit even for a depth of one.
package sram_port_arbiter_pkg;

  localparam logic MST_INST = 1'b0;
  localparam logic MST_DATA = 1'b1;

  localparam int unsigned MAX_OUTST_DEFAULT = 2;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// Issue-order tag FIFO: remembers which requester owns each outstanding transaction.
// One bit wide, Depth deep, synchronous active-low reset.
// Ports:
//   clk, resetn         clock / synchronous active-low reset
//   push_i, push_id_i   enqueue a requester id (ignored when full)
//   pop_i               dequeue the head (ignored when empty)
//   full_o, empty_o     occupancy flags, from registered state only
//   head_o              id of the oldest outstanding transaction
module arb_tag_fifo
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned Depth = MAX_OUTST_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic push_i,
  input  logic push_id_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int unsigned PtrW = ptr_width(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Depth-1:0] tags_q, tags_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  // Explicit wrap so a depth of one keeps the pointers at zero.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = tags_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    tags_d   = tags_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      tags_d[wr_ptr_q] = push_id_i;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      tags_q   <= tags_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one sram-like memory port between instruction fetch and load/store.
// Requests are muxed onto mem_*; responses are steered back in issue order using a tag FIFO.
// Optional feature macro: ARB_ROUND_ROBIN_EN -- round-robin on conflict instead of
// fixed data-over-inst priority.
// Ports:
//   clk, resetn                         clock / synchronous active-low reset
//   inst_req/addr, inst_addr_ok         fetch request side (read only)
//   inst_data_ok, inst_rdata            fetch response
//   data_req/wstrb/addr/wdata           load/store request (wstrb==0 means read)
//   data_addr_ok, data_data_ok, data_rdata
//   mem_req/wstrb/addr/wdata, mem_addr_ok   downstream request channel
//   mem_data_ok, mem_rdata                  downstream in-order responses
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUTST = MAX_OUTST_DEFAULT
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  logic sel;
  logic sel_req;
  logic conflict_winner;
  logic handshake;
  logic pop;
  logic fifo_full, fifo_empty, fifo_head;
  logic lock_q, lock_d;
  logic lock_mst_q, lock_mst_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_last_q, rr_last_d;

  assign conflict_winner = ~rr_last_q;

  always_comb begin
    rr_last_d = rr_last_q;
    if (handshake) begin
      rr_last_d = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_last_q <= MST_INST;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`else
  assign conflict_winner = MST_DATA;
`endif

  // A stalled request keeps its master selected so the downstream sees a stable request.
  always_comb begin
    sel = MST_INST;
    if (lock_q) begin
      sel = lock_mst_q;
    end else if (inst_req && data_req) begin
      sel = conflict_winner;
    end else if (data_req) begin
      sel = MST_DATA;
    end
  end

  assign sel_req   = (sel == MST_DATA) ? data_req : inst_req;
  assign mem_req   = resetn & sel_req & ~fifo_full;
  assign mem_addr  = (sel == MST_DATA) ? data_addr : inst_addr;
  assign mem_wstrb = (sel == MST_DATA) ? data_wstrb : '0;
  assign mem_wdata = (sel == MST_DATA) ? data_wdata : '0;

  assign handshake    = mem_req & mem_addr_ok;
  assign inst_addr_ok = handshake & (sel == MST_INST);
  assign data_addr_ok = handshake & (sel == MST_DATA);

  // Responses with nothing outstanding are dropped.
  assign pop          = resetn & mem_data_ok & ~fifo_empty;
  assign inst_data_ok = pop & (fifo_head == MST_INST);
  assign data_data_ok = pop & (fifo_head == MST_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_comb begin
    lock_d     = lock_q;
    lock_mst_d = lock_mst_q;
    if (handshake) begin
      lock_d = 1'b0;
    end else if (mem_req) begin
      lock_d     = 1'b1;
      lock_mst_d = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_q     <= 1'b0;
      lock_mst_q <= MST_INST;
    end else begin
      lock_q     <= lock_d;
      lock_mst_q <= lock_mst_d;
    end
  end

  arb_tag_fifo #(
    .Depth(MAX_OUTST)
  ) u_tag_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push_i   (handshake),
    .push_id_i(sel),
    .pop_i    (pop),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .head_o   (fifo_head)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (!(mem_data_ok && fifo_empty))
        else $error("sram_port_arbiter: mem_data_ok with no outstanding transaction");
    end
  end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter (default MAX_OUTST=2).
module tb_sram_port_arbiter;
  import sram_port_arbiter_pkg::*;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  sram_port_arbiter dut (
    .clk         (clk),
    .resetn      (resetn),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wstrb  (data_wstrb),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .mem_req     (mem_req),
    .mem_wstrb   (mem_wstrb),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    inst_req    = 1'b0;
    inst_addr   = '0;
    data_req    = 1'b0;
    data_wstrb  = '0;
    data_addr   = '0;
    data_wdata  = '0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
  endtask

  bit   rr_mode;
  logic exp_g;
  logic prev_g;

  initial begin
    rr_mode = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    rr_mode = 1'b1;
`endif

    // Reset: everything forced low even with requests and responses asserted.
    resetn = 1'b0;
    idle_inputs();
    inst_req    = 1'b1;
    data_req    = 1'b1;
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_inst_addr_ok", inst_addr_ok, 0);
    chk("rst_data_addr_ok", data_addr_ok, 0);
    chk("rst_inst_data_ok", inst_data_ok, 0);
    chk("rst_data_data_ok", data_data_ok, 0);
    tick();
    tick();
    idle_inputs();
    resetn = 1'b1;

    // 1. Idle.
    settle();
    chk("idle_mem_req", mem_req, 0);
    chk("idle_inst_addr_ok", inst_addr_ok, 0);
    chk("idle_data_addr_ok", data_addr_ok, 0);
    chk("idle_inst_data_ok", inst_data_ok, 0);
    chk("idle_data_data_ok", data_data_ok, 0);
    tick();

    // 2. Single fetch.
    inst_req    = 1'b1;
    inst_addr   = 32'h1c00_0000;
    mem_addr_ok = 1'b1;
    settle();
    chk("t2_mem_req", mem_req, 1);
    chk("t2_mem_addr", mem_addr, 32'h1c00_0000);
    chk("t2_mem_wstrb", mem_wstrb, 0);
    chk("t2_inst_addr_ok", inst_addr_ok, 1);
    chk("t2_data_addr_ok", data_addr_ok, 0);
    tick();
    idle_inputs();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h0280_0c0c;
    settle();
    chk("t2_inst_data_ok", inst_data_ok, 1);
    chk("t2_inst_rdata", inst_rdata, 32'h0280_0c0c);
    chk("t2_data_data_ok", data_data_ok, 0);
    chk("t2_mem_req_after", mem_req, 0);
    tick();
    idle_inputs();

    // 3. Conflict with stalled downstream: data wins and stays selected.
    inst_req  = 1'b1;
    inst_addr = 32'h0000_0100;
    data_req  = 1'b1;
    data_addr = 32'h0000_0200;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t3_stall_mem_req", mem_req, 1);
      chk("t3_stall_mem_addr", mem_addr, 32'h0000_0200);
      chk("t3_stall_data_addr_ok", data_addr_ok, 0);
      chk("t3_stall_inst_addr_ok", inst_addr_ok, 0);
      tick();
    end
    mem_addr_ok = 1'b1;
    settle();
    chk("t3_hs_mem_addr", mem_addr, 32'h0000_0200);
    chk("t3_hs_data_addr_ok", data_addr_ok, 1);
    chk("t3_hs_inst_addr_ok", inst_addr_ok, 0);
    tick();
    data_req = 1'b0;
    settle();
    chk("t3_inst_addr_ok", inst_addr_ok, 1);
    chk("t3_inst_mem_addr", mem_addr, 32'h0000_0100);
    tick();
    idle_inputs();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h0000_00aa;
    settle();
    chk("t3_rsp1_data_data_ok", data_data_ok, 1);
    chk("t3_rsp1_inst_data_ok", inst_data_ok, 0);
    chk("t3_rsp1_data_rdata", data_rdata, 32'h0000_00aa);
    tick();
    mem_rdata = 32'h0000_00bb;
    settle();
    chk("t3_rsp2_inst_data_ok", inst_data_ok, 1);
    chk("t3_rsp2_data_data_ok", data_data_ok, 0);
    tick();
    idle_inputs();

    // Lock held by inst even when data arrives afterwards.
    inst_req  = 1'b1;
    inst_addr = 32'h0000_0300;
    settle();
    chk("lk_mem_req", mem_req, 1);
    tick();
    data_req  = 1'b1;
    data_addr = 32'h0000_0400;
    settle();
    chk("lk_mem_addr", mem_addr, 32'h0000_0300);
    chk("lk_data_addr_ok", data_addr_ok, 0);
    tick();
    mem_addr_ok = 1'b1;
    settle();
    chk("lk_hs_inst_addr_ok", inst_addr_ok, 1);
    chk("lk_hs_data_addr_ok", data_addr_ok, 0);
    tick();
    inst_req = 1'b0;
    settle();
    chk("lk_next_data_addr_ok", data_addr_ok, 1);
    tick();
    idle_inputs();
    mem_data_ok = 1'b1;
    settle();
    chk("lk_rsp1_inst_data_ok", inst_data_ok, 1);
    tick();
    settle();
    chk("lk_rsp2_data_data_ok", data_data_ok, 1);
    tick();
    idle_inputs();

    // 4. FIFO full: third fetch waits until a slot frees.
    inst_req    = 1'b1;
    inst_addr   = 32'h0000_1000;
    mem_addr_ok = 1'b1;
    settle();
    chk("t4_acc1", inst_addr_ok, 1);
    tick();
    settle();
    chk("t4_acc2", inst_addr_ok, 1);
    tick();
    mem_data_ok = 1'b1;
    settle();
    chk("t4_full_mem_req", mem_req, 0);
    chk("t4_full_inst_addr_ok", inst_addr_ok, 0);
    chk("t4_full_pop_inst_data_ok", inst_data_ok, 1);
    tick();
    mem_data_ok = 1'b0;
    settle();
    chk("t4_freed_mem_req", mem_req, 1);
    chk("t4_acc3", inst_addr_ok, 1);
    tick();
    idle_inputs();
    mem_data_ok = 1'b1;
    settle();
    chk("t4_drain1", inst_data_ok, 1);
    tick();
    settle();
    chk("t4_drain2", inst_data_ok, 1);
    tick();
    idle_inputs();

    // 5. Store then fetch, with push and pop in the same cycle; order preserved.
    data_req    = 1'b1;
    data_wstrb  = 4'b0011;
    data_addr   = 32'h0000_0800;
    data_wdata  = 32'hdead_beef;
    mem_addr_ok = 1'b1;
    settle();
    chk("t5_st_mem_wstrb", mem_wstrb, 4'b0011);
    chk("t5_st_mem_wdata", mem_wdata, 32'hdead_beef);
    chk("t5_st_mem_addr", mem_addr, 32'h0000_0800);
    chk("t5_st_data_addr_ok", data_addr_ok, 1);
    tick();
    data_req    = 1'b0;
    inst_req    = 1'b1;
    inst_addr   = 32'h1c00_0004;
    mem_data_ok = 1'b1;
    settle();
    chk("t5_ld_mem_wstrb", mem_wstrb, 0);
    chk("t5_ld_mem_wdata", mem_wdata, 0);
    chk("t5_ld_inst_addr_ok", inst_addr_ok, 1);
    chk("t5_rsp1_data_data_ok", data_data_ok, 1);
    chk("t5_rsp1_inst_data_ok", inst_data_ok, 0);
    tick();
    idle_inputs();
    mem_data_ok = 1'b1;
    settle();
    chk("t5_rsp2_inst_data_ok", inst_data_ok, 1);
    chk("t5_rsp2_data_data_ok", data_data_ok, 0);
    tick();
    idle_inputs();

    // Reset mid-transaction discards the outstanding data tag.
    data_req    = 1'b1;
    data_addr   = 32'h0000_0040;
    mem_addr_ok = 1'b1;
    settle();
    chk("mr_data_addr_ok", data_addr_ok, 1);
    tick();
    idle_inputs();
    resetn = 1'b0;
    tick();
    resetn      = 1'b1;
    inst_req    = 1'b1;
    inst_addr   = 32'h0000_0044;
    mem_addr_ok = 1'b1;
    settle();
    chk("mr_inst_addr_ok", inst_addr_ok, 1);
    tick();
    idle_inputs();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h0000_0055;
    settle();
    chk("mr_inst_data_ok", inst_data_ok, 1);
    chk("mr_data_data_ok", data_data_ok, 0);
    tick();
    idle_inputs();

    // 6. Continuous conflict: fixed priority or alternation.
    prev_g = MST_INST;
    for (int i = 0; i < 4; i++) begin
      inst_req    = 1'b1;
      data_req    = 1'b1;
      mem_addr_ok = 1'b1;
      mem_data_ok = (i > 0);
      exp_g = (rr_mode && (i % 2 == 1)) ? MST_INST : MST_DATA;
      settle();
      chk("t6_data_addr_ok", data_addr_ok, exp_g == MST_DATA);
      chk("t6_inst_addr_ok", inst_addr_ok, exp_g == MST_INST);
      if (i > 0) begin
        chk("t6_rsp_data_data_ok", data_data_ok, prev_g == MST_DATA);
      end
      prev_g = exp_g;
      tick();
    end
    idle_inputs();
    mem_data_ok = 1'b1;
    settle();
    chk("t6_last_data_data_ok", data_data_ok, prev_g == MST_DATA);
    chk("t6_last_inst_data_ok", inst_data_ok, prev_g == MST_INST);
    tick();
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
